// File: rtl/door_pkg.sv
`default_nettype none
// ============================================================================
// Module      : door_pkg
// Description : Shared state/direction encodings and default sizing for the
//               door access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package door_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_grant = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    localparam logic c_dir_ent  = 1'b0;
    localparam logic c_dir_exit = 1'b1;

    localparam int c_def_capacity = 10;
    localparam int c_def_cnt_w    = 4;
    localparam int c_def_hold_cyc = 3;

endpackage
`default_nettype wire

// File: rtl/door_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : door_hold_timer
// Description : Loadable down-counter with zero flag timing the door hold.
// Revision    : 1.0 - initial release
// ============================================================================
module door_hold_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/door_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : door_access_arbiter
// Description : Shares one door between entry/exit requesters, holds it open
//               for a fixed time and tracks occupancy. Define DOOR_RR_EN for
//               round-robin tie-breaking (default: exit has priority).
// Revision    : 1.0 - initial release
// ============================================================================
module door_access_arbiter
    import door_pkg::*;
#(
    parameter int CAPACITY = c_def_capacity,
    parameter int CNT_W    = c_def_cnt_w,
    parameter int HOLD_CYC = c_def_hold_cyc
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ent_req,
    input  logic             exit_req,
    output logic             ent_gnt,
    output logic             exit_gnt,
    output logic             door_open,
    output logic             busy,
    output logic             reject,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_ent_gnt, r_exit_gnt, r_door_open, r_reject;
    logic [CNT_W-1:0] r_count;
    logic             w_ent_gnt_d, w_exit_gnt_d, w_door_open_d, w_reject_d;
    logic [CNT_W-1:0] w_count_d;
    logic             w_ent_v, w_exit_v, w_grant, w_dir_sel, w_tie_dir;
    logic             w_full, w_empty, w_hold_zero;

    assign w_full   = (r_count == CNT_W'(CAPACITY));
    assign w_empty  = (r_count == '0);
    assign w_ent_v  = ent_req  & ~w_full;
    assign w_exit_v = exit_req & ~w_empty;
    assign w_grant  = (r_state == c_st_idle) & (w_ent_v | w_exit_v);

`ifdef DOOR_RR_EN
    logic r_last_dir;

    // Starts at exit so that the first tie after reset favours entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_dir <= c_dir_exit;
        end else if (w_grant) begin
            r_last_dir <= w_dir_sel;
        end
    end

    assign w_tie_dir = (r_last_dir == c_dir_exit) ? c_dir_ent : c_dir_exit;
`else
    assign w_tie_dir = c_dir_exit;
`endif

    assign w_dir_sel = (w_ent_v && w_exit_v) ? w_tie_dir :
                       (w_ent_v ? c_dir_ent : c_dir_exit);

    door_hold_timer #(.W(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (r_state == c_st_grant),
        .load_val (HOLD_W'(HOLD_CYC - 1)),
        .dec      (r_state == c_st_hold),
        .zero     (w_hold_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_ent_gnt   <= 1'b0;
            r_exit_gnt  <= 1'b0;
            r_door_open <= 1'b0;
            r_reject    <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ent_gnt   <= w_ent_gnt_d;
            r_exit_gnt  <= w_exit_gnt_d;
            r_door_open <= w_door_open_d;
            r_reject    <= w_reject_d;
            r_count     <= w_count_d;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_ent_v || w_exit_v) w_next_state = c_st_grant;
            c_st_grant: w_next_state = c_st_hold;
            c_st_hold:  if (w_hold_zero) w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // Outputs are registered, so this computes their values for the next cycle;
    // count moves on the same edge the grant pulse appears.
    always_comb begin
        w_ent_gnt_d   = w_grant & (w_dir_sel == c_dir_ent);
        w_exit_gnt_d  = w_grant & (w_dir_sel == c_dir_exit);
        w_door_open_d = (w_next_state != c_st_idle);
        w_reject_d    = (r_state == c_st_idle) &
                        ((ent_req & w_full) | (exit_req & w_empty));
        w_count_d     = r_count;
        if (w_ent_gnt_d) begin
            w_count_d = r_count + CNT_W'(1);
        end else if (w_exit_gnt_d) begin
            w_count_d = r_count - CNT_W'(1);
        end
    end

    assign ent_gnt   = r_ent_gnt;
    assign exit_gnt  = r_exit_gnt;
    assign door_open = r_door_open;
    assign reject    = r_reject;
    assign count     = r_count;
    assign busy      = (r_state != c_st_idle);
    assign full      = w_full;
    assign empty     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_door_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_door_access_arbiter
// Description : Directed self-checking bench for door_access_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_door_access_arbiter;

    logic       clk = 1'b0;
    logic       rst, ent_req, exit_req;
    logic       ent_gnt, exit_gnt, door_open, busy, reject, full, empty;
    logic [3:0] count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    door_access_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .ent_req   (ent_req),
        .exit_req  (exit_req),
        .ent_gnt   (ent_gnt),
        .exit_gnt  (exit_gnt),
        .door_open (door_open),
        .busy      (busy),
        .reject    (reject),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        check_val("idle_timeout", 32'(busy), 0);
    endtask

    task automatic do_entry(input int exp_cnt);
        ent_req = 1'b1;
        tick();
        check_val("entry_gnt", 32'(ent_gnt), 1);
        check_val("entry_cnt", 32'(count), 32'(exp_cnt));
        ent_req = 1'b0;
        wait_idle();
    endtask

    task automatic do_exit(input int exp_cnt);
        exit_req = 1'b1;
        tick();
        check_val("exit_gnt", 32'(exit_gnt), 1);
        check_val("exit_cnt", 32'(count), 32'(exp_cnt));
        exit_req = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; ent_req = 1'b0; exit_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_val("rst_door", 32'(door_open), 0);
        check_val("rst_count", 32'(count), 0);
        check_val("rst_empty", 32'(empty), 1);
        check_val("rst_full", 32'(full), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_gnt", 32'({ent_gnt, exit_gnt, reject}), 0);

        // First entry: grant at t+1, door open t+1..t+4, closed at t+5.
        ent_req = 1'b1;
        tick();
        check_val("e1_gnt", 32'(ent_gnt), 1);
        check_val("e1_door", 32'(door_open), 1);
        check_val("e1_count", 32'(count), 1);
        ent_req = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check_val("e1_hold_door", 32'(door_open), 1);
            check_val("e1_hold_gnt", 32'(ent_gnt), 0);
        end
        tick();
        check_val("e1_close_door", 32'(door_open), 0);
        check_val("e1_close_busy", 32'(busy), 0);

        for (int n = 2; n <= 10; n++) do_entry(n);
        check_val("full_flag", 32'(full), 1);

        // Entry refused while full, repeated each idle cycle.
        ent_req = 1'b1;
        tick();
        check_val("full_rej", 32'(reject), 1);
        check_val("full_nognt", 32'(ent_gnt), 0);
        tick();
        check_val("full_rej2", 32'(reject), 1);
        check_val("full_door", 32'(door_open), 0);
        ent_req = 1'b0;
        tick();
        check_val("full_rej_end", 32'(reject), 0);
        check_val("full_count", 32'(count), 10);

        for (int n = 9; n >= 5; n--) do_exit(n);

        // Tie at count 5.
        ent_req = 1'b1; exit_req = 1'b1;
        tick();
`ifdef DOOR_RR_EN
        check_val("tie1_ent", 32'(ent_gnt), 1);
        check_val("tie1_exit", 32'(exit_gnt), 0);
        check_val("tie1_count", 32'(count), 6);
        ent_req = 1'b0;
`else
        check_val("tie1_ent", 32'(ent_gnt), 0);
        check_val("tie1_exit", 32'(exit_gnt), 1);
        check_val("tie1_count", 32'(count), 4);
        exit_req = 1'b0;
`endif
        wait_idle();
        tick();
`ifdef DOOR_RR_EN
        check_val("tie2_exit", 32'(exit_gnt), 1);
        exit_req = 1'b0;
`else
        check_val("tie2_ent", 32'(ent_gnt), 1);
        ent_req = 1'b0;
`endif
        check_val("tie_final", 32'(count), 5);
        wait_idle();

        // Exit raised mid-hold is ignored until the arbiter is idle again.
        ent_req = 1'b1;
        tick();
        check_val("mh_ent_gnt", 32'(ent_gnt), 1);
        ent_req = 1'b0;
        tick();
        exit_req = 1'b1;
        tick();
        check_val("mh_gnt_t3", 32'(exit_gnt), 0);
        tick();
        check_val("mh_gnt_t4", 32'(exit_gnt), 0);
        tick();
        check_val("mh_gnt_t5", 32'(exit_gnt), 0);
        check_val("mh_door_t5", 32'(door_open), 0);
        tick();
        check_val("mh_gnt_t6", 32'(exit_gnt), 1);
        check_val("mh_count", 32'(count), 5);
        exit_req = 1'b0;
        wait_idle();

        do_exit(4);
        do_exit(3);

        // Reset in the middle of a hold.
        ent_req = 1'b1;
        tick();
        ent_req = 1'b0;
        tick();
        check_val("rh_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        tick();
        check_val("rh_door", 32'(door_open), 0);
        check_val("rh_count", 32'(count), 0);
        check_val("rh_empty", 32'(empty), 1);
        check_val("rh_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // Exit refused while empty.
        exit_req = 1'b1;
        tick();
        check_val("emp_rej", 32'(reject), 1);
        check_val("emp_nognt", 32'(exit_gnt), 0);
        check_val("emp_empty", 32'(empty), 1);
        check_val("emp_door", 32'(door_open), 0);
        exit_req = 1'b0;
        tick();
        check_val("emp_rej_end", 32'(reject), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
